// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver: hex decode, leading-zero suppression,
// per-digit blank/dp, and display updates that take effect only at frame boundaries.
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lzs_en,
    output logic [0:6]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    pending,
    output logic                    frame_done
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic SEG_INV = 1'(SEG_ACTIVE_LOW != 0);
    localparam logic AN_INV  = 1'(AN_ACTIVE_LOW != 0);

    // Logical segment pattern (1 = lit), bit 6 = a ... bit 0 = g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h7E;
            4'h1:    pat = 7'h30;
            4'h2:    pat = 7'h6D;
            4'h3:    pat = 7'h79;
            4'h4:    pat = 7'h33;
            4'h5:    pat = 7'h5B;
            4'h6:    pat = 7'h5F;
            4'h7:    pat = 7'h70;
            4'h8:    pat = 7'h7F;
            4'h9:    pat = 7'h73;
            4'hA:    pat = 7'h77;
            4'hB:    pat = 7'h1F;
            4'hC:    pat = 7'h4E;
            4'hD:    pat = 7'h3D;
            4'hE:    pat = 7'h4F;
            4'hF:    pat = 7'h47;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

    logic [DIV_W-1:0]          div_r;
    logic [IDX_W-1:0]          idx_r;
    logic                      frame_done_r;
    logic [4*NUM_DIGITS-1:0]   pend_data_r;
    logic [NUM_DIGITS-1:0]     pend_dp_r;
    logic [NUM_DIGITS-1:0]     pend_blank_r;
    logic                      pend_lzs_r;
    logic                      pending_r;
    logic [4*NUM_DIGITS-1:0]   disp_data_r;
    logic [NUM_DIGITS-1:0]     disp_dp_r;
    logic [NUM_DIGITS-1:0]     disp_blank_r;
    logic                      disp_lzs_r;
    logic [0:6]                seg_r;
    logic                      dp_r;
    logic [NUM_DIGITS-1:0]     an_r;

    logic                      tick_s;
    logic                      boundary_s;
    logic [3:0]                nib_s [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]     sup_s;
    logic                      upper_zero_s;
    logic                      dark_s;
    logic [6:0]                seg_lg_s;
    logic                      dp_lg_s;
    logic [NUM_DIGITS-1:0]     an_lg_s;

    // Slot tick and frame boundary detection.
    always_comb begin
        tick_s     = (div_r == DIV_LAST);
        boundary_s = tick_s && (idx_r == IDX_LAST);
    end

    // Split the display word into per-digit nibbles.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib_s[i] = disp_data_r[4*i +: 4];
        end
    end

    // Walk down from the top digit; a forced-blank digit reads as zero here.
    always_comb begin
        upper_zero_s = 1'b1;
        sup_s        = {NUM_DIGITS{1'b0}};
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero_s = upper_zero_s && ((nib_s[i] == 4'h0) || disp_blank_r[i]);
            sup_s[i]     = disp_lzs_r && upper_zero_s;
        end
    end

    // Logical outputs for the digit currently being scanned.
    always_comb begin
        dark_s  = disp_blank_r[idx_r] || sup_s[idx_r];
        an_lg_s = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_r;
        if (dark_s) begin
            seg_lg_s = 7'h00;
            dp_lg_s  = 1'b0;
        end else begin
            seg_lg_s = hex_to_seg(nib_s[idx_r]);
            dp_lg_s  = disp_dp_r[idx_r];
        end
    end

    // Refresh divider, digit index and frame-done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r        <= {DIV_W{1'b0}};
            idx_r        <= {IDX_W{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= boundary_s;
            if (tick_s) begin
                div_r <= {DIV_W{1'b0}};
                idx_r <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
            end else begin
                div_r <= div_r + DIV_W'(1);
            end
        end
    end

    // Double buffering: commit of old pending data happens before a same-edge load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_data_r  <= {(4*NUM_DIGITS){1'b0}};
            pend_dp_r    <= {NUM_DIGITS{1'b0}};
            pend_blank_r <= {NUM_DIGITS{1'b0}};
            pend_lzs_r   <= 1'b0;
            pending_r    <= 1'b0;
            disp_data_r  <= {(4*NUM_DIGITS){1'b0}};
            disp_dp_r    <= {NUM_DIGITS{1'b0}};
            disp_blank_r <= {NUM_DIGITS{1'b0}};
            disp_lzs_r   <= 1'b0;
        end else begin
            if (boundary_s && pending_r) begin
                disp_data_r  <= pend_data_r;
                disp_dp_r    <= pend_dp_r;
                disp_blank_r <= pend_blank_r;
                disp_lzs_r   <= pend_lzs_r;
            end
            if (load) begin
                pend_data_r  <= data_in;
                pend_dp_r    <= dp_in;
                pend_blank_r <= blank_in;
                pend_lzs_r   <= lzs_en;
                pending_r    <= 1'b1;
            end else if (boundary_s) begin
                pending_r    <= 1'b0;
            end
        end
    end

    // Registered pin outputs with polarity applied last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r <= {7{SEG_INV}};
            dp_r  <= SEG_INV;
            an_r  <= {NUM_DIGITS{AN_INV}};
        end else begin
            seg_r <= seg_lg_s ^ {7{SEG_INV}};
            dp_r  <= dp_lg_s ^ SEG_INV;
            an_r  <= an_lg_s ^ {NUM_DIGITS{AN_INV}};
        end
    end

    assign seg        = seg_r;
    assign dp         = dp_r;
    assign an         = an_r;
    assign pending    = pending_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (REFRESH_DIV=4, NUM_DIGITS=4, active-low outputs):
// an event-level model checked every cycle plus literal checks of decoded digits.
module tb_seg7_scan_driver;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        load     = 1'b0;
    logic [15:0] data_in  = 16'h0000;
    logic [3:0]  dp_in    = 4'h0;
    logic [3:0]  blank_in = 4'h0;
    logic        lzs_en   = 1'b0;
    logic [0:6]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        pending;
    logic        frame_done;

    seg7_scan_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .dp_in(dp_in),
        .blank_in(blank_in), .lzs_en(lzs_en), .seg(seg), .dp(dp), .an(an),
        .pending(pending), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [6:0] pat_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // model state: cycles since reset release plus the two data buffers
    int          m_k = 0;
    logic [15:0] m_disp = 16'h0, m_pdata = 16'h0, m_eff;
    logic [3:0]  m_dpv = 4'h0, m_blank = 4'h0, m_pdp = 4'h0, m_pblank = 4'h0, m_nib;
    logic        m_lzs = 1'b0, m_plzs = 1'b0, m_pending = 1'b0, m_bnd, m_dark;
    int          m_d;
    logic [6:0]  exp_seg = 7'h7F;
    logic        exp_dp = 1'b1, exp_fd = 1'b0, exp_pend = 1'b0;
    logic [3:0]  exp_an = 4'hF;
    logic [6:0]  last_seg [4] = '{7'h7F, 7'h7F, 7'h7F, 7'h7F};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: digit = (cycles/4)%4, boundary every 16th cycle, buffers per the load/commit rules.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_k = 0; m_disp = 16'h0; m_dpv = 4'h0; m_blank = 4'h0; m_lzs = 1'b0;
                m_pdata = 16'h0; m_pdp = 4'h0; m_pblank = 4'h0; m_plzs = 1'b0; m_pending = 1'b0;
                exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF; exp_fd = 1'b0; exp_pend = 1'b0;
            end else begin
                m_d   = (m_k / 4) % 4;
                m_bnd = ((m_k % 16) == 15);
                m_eff = m_disp;
                for (int j = 0; j < 4; j++) if (m_blank[j]) m_eff[4*j +: 4] = 4'h0;
                m_nib  = m_disp[4*m_d +: 4];
                m_dark = m_blank[m_d] || (m_lzs && m_d > 0 && ((m_eff >> (4*m_d)) == 16'h0));
                exp_seg = m_dark ? 7'h7F : ~pat_tab[m_nib];
                exp_dp  = m_dark ? 1'b1 : ~m_dpv[m_d];
                exp_an  = ~(4'b0001 << m_d);
                exp_fd  = m_bnd;
                if (m_bnd && m_pending) begin
                    m_disp = m_pdata; m_dpv = m_pdp; m_blank = m_pblank; m_lzs = m_plzs;
                end
                if (load) begin
                    m_pdata = data_in; m_pdp = dp_in; m_pblank = blank_in; m_plzs = lzs_en;
                    m_pending = 1'b1;
                end else if (m_bnd) begin
                    m_pending = 1'b0;
                end
                exp_pend = m_pending;
                m_k++;
            end
        end
    end

    // Per-cycle comparison against the model; also remember what each digit showed.
    initial begin
        forever begin
            @(negedge clk);
            check("seg", 32'(seg), 32'(exp_seg));
            check("dp", 32'(dp), 32'(exp_dp));
            check("an", 32'(an), 32'(exp_an));
            check("frame_done", 32'(frame_done), 32'(exp_fd));
            check("pending", 32'(pending), 32'(exp_pend));
            for (int d = 0; d < 4; d++) if (an[d] == 1'b0) last_seg[d] = seg;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b, input logic z);
        data_in = d; dp_in = p; blank_in = b; lzs_en = z; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_fd();
        int c;
        c = 0;
        @(negedge clk);
        while (frame_done !== 1'b1 && c < 40) begin
            @(negedge clk);
            c++;
        end
        check("frame_wait", 32'(frame_done), 32'd1);
    endtask

    task automatic check_digits(input string name, input int n, input logic [6:0] e3,
                                input logic [6:0] e2, input logic [6:0] e1, input logic [6:0] e0);
        tick(n);
        #1;
        check({name, "_d3"}, 32'(last_seg[3]), 32'(e3));
        check({name, "_d2"}, 32'(last_seg[2]), 32'(e2));
        check({name, "_d1"}, 32'(last_seg[1]), 32'(e1));
        check({name, "_d0"}, 32'(last_seg[0]), 32'(e0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int fd_first;
        int fd_second;
        fd_first  = -1;
        fd_second = -1;

        tick(3);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_an", 32'(an), 32'hF);
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_pend", 32'(pending), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);
        rst_n = 1'b1;

        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c <= 16) check("an_scan", 32'(an), 32'(an_tab[(c-1)/4]));
            if (c == 1) check("zero_d0", 32'(seg), 32'h01);
            if (frame_done === 1'b1) begin
                if (fd_first < 0) fd_first = c;
                else if (fd_second < 0) fd_second = c;
            end
        end
        check("fd_first", 32'(fd_first), 32'd16);
        check("fd_second", 32'(fd_second), 32'd32);

        do_load(16'h12AF, 4'b0100, 4'h0, 1'b0);
        check("pend_set", 32'(pending), 32'd1);
        wait_fd();
        check("pend_clr", 32'(pending), 32'd0);
        check_digits("hex", 16, 7'h4F, 7'h12, 7'h08, 7'h38);

        do_load(16'h0040, 4'h0, 4'h0, 1'b1);
        wait_fd();
        check_digits("lzs40", 16, 7'h7F, 7'h7F, 7'h4C, 7'h01);

        do_load(16'h0000, 4'h0, 4'h0, 1'b1);
        wait_fd();
        check_digits("lzs0", 16, 7'h7F, 7'h7F, 7'h7F, 7'h01);

        do_load(16'h0000, 4'hF, 4'b0001, 1'b1);
        wait_fd();
        check_digits("blank0", 16, 7'h7F, 7'h7F, 7'h7F, 7'h7F);

        // load A mid-frame, B exactly on the boundary edge, then C overwrites B
        wait_fd();
        do_load(16'h5678, 4'h0, 4'h0, 1'b0);
        tick(14);
        do_load(16'h9999, 4'h0, 4'h0, 1'b0);
        check("bnd_fd", 32'(frame_done), 32'd1);
        check("bnd_pend", 32'(pending), 32'd1);
        tick(4);
        do_load(16'hBCDE, 4'h0, 4'h0, 1'b0);
        check("ovr_pend", 32'(pending), 32'd1);
        wait_fd();
        check_digits("bnd_a", 0, 7'h24, 7'h20, 7'h0F, 7'h00);
        check_digits("ovr_c", 16, 7'h60, 7'h31, 7'h42, 7'h30);

        // asynchronous reset with data still pending
        do_load(16'h8888, 4'hF, 4'h0, 1'b0);
        tick(3);
        check("pre_rst_pend", 32'(pending), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_seg", 32'(seg), 32'h7F);
        check("arst_an", 32'(an), 32'hF);
        check("arst_dp", 32'(dp), 32'd1);
        check("arst_pend", 32'(pending), 32'd0);
        tick(2);
        rst_n = 1'b1;
        check_digits("post_rst", 40, 7'h01, 7'h01, 7'h01, 7'h01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 The module SHALL have parameter NUM_DIGITS, default 4, giving the number of multiplexed digits (legal range 2..8).
REQ-002 The module SHALL have parameter REFRESH_DIV, default 50000, giving the clock cycles per digit slot (minimum 2).
REQ-003 The module SHALL have parameter SEG_ACTIVE_LOW, default 1; when 1, segment and dp outputs are active-low.
REQ-004 The module SHALL have parameter AN_ACTIVE_LOW, default 1; when 1, digit enables are active-low.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 load  input  1  one-cycle strobe that captures data_in, dp_in, blank_in and lzs_en.
REQ-008 data_in  input  4*NUM_DIGITS  hex nibbles, nibble 0 in bits [3:0] is the rightmost (least significant) digit.
REQ-009 dp_in  input  NUM_DIGITS  per-digit decimal point request, active-high.
REQ-010 blank_in  input  NUM_DIGITS  per-digit forced blank, active-high.
REQ-011 lzs_en  input  1  leading-zero suppression enable.
REQ-012 seg  output  7, indexed [0:6]  segments a..g, with seg[0]=a.
REQ-013 dp  output  1  decimal point of the active digit.
REQ-014 an  output  NUM_DIGITS  one-hot digit enable.
REQ-015 pending  output  1  high while captured data awaits commit.
REQ-016 frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-017 A divider counter SHALL count 0..REFRESH_DIV-1 and wrap; the cycle in which it equals REFRESH_DIV-1 is a "tick".
REQ-018 The digit index SHALL advance by 1 on each tick and wrap from NUM_DIGITS-1 to 0; that wrapping tick is the "frame boundary".
REQ-019 On load, the inputs SHALL be captured into a pending register and pending SHALL be set; a load while pending is already set SHALL overwrite the pending data (last write wins).
REQ-020 At a frame boundary with pending=1, pending data SHALL be copied to the display register and pending SHALL clear in the same edge.
REQ-021 A load coinciding with a frame boundary SHALL commit the previously pending data, if any, and SHALL leave the new data pending (pending=1).
REQ-022 frame_done SHALL be high for exactly the one cycle following each frame boundary edge.
REQ-023 The decode SHALL use logical segment patterns (1 = lit): 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=73, A=77, b=1F, C=4E, d=3D, E=4F, F=47, with the bit order a..g MSB-first.
REQ-024 A digit SHALL be blanked (all segments and dp off) if its blank_in bit is set or it is suppressed.
REQ-025 With lzs_en=1, a digit SHALL be suppressed when it and every more-significant digit is zero; digit 0 SHALL never be suppressed.
REQ-026 A forced-blank digit SHALL NOT count as nonzero for suppression purposes.
REQ-027 dp SHALL follow dp_in of the active digit unless that digit is blanked.
REQ-028 seg, dp and an SHALL be registered and reflect the digit index with exactly one cycle of latency.
REQ-029 an SHALL be one-hot (logical) at all times after the first cycle following reset.
REQ-030 Output polarity SHALL be applied last: logical outputs are inverted when SEG_ACTIVE_LOW or AN_ACTIVE_LOW is 1.

Reset
REQ-031 While rst_n=0, the following SHALL hold: divider=0, digit index=0, display and pending registers all-zero, pending=0, frame_done=0, all segments/dp off, and an all-inactive (all ones with the defaults).
REQ-032 A reset asserted mid-frame or mid-pending SHALL discard pending data immediately without committing it.
REQ-033 After reset release, scanning SHALL restart at digit 0, and the display SHALL show "0" on digit 0 with the other digits showing "0" (lzs_en reset value is 0).

Verification
REQ-034 Bench: REFRESH_DIV=4, NUM_DIGITS=4, defaults -> an cycles 1110,1101,1011,0111 with 4 cycles each, and frame_done pulses every 16 cycles.
REQ-035 Bench: load data_in=16'h12AF -> no display change before the frame boundary; after it, digits 3..0 show seg 7'h4F,7'h12,7'h08,7'h38, and pending falls.
REQ-036 Bench: lzs_en=1, data_in=16'h0040 -> digits 3 and 2 blank (7'h7F), digit 1 shows 7'h4C, digit 0 shows 7'h01.
REQ-037 Bench: data_in=16'h0000 with lzs_en=1 -> only digit 0 lit (7'h01); adding blank_in=4'b0001 -> all digits dark.
REQ-038 Bench: load at the exact frame-boundary cycle, then a second load -> the first data is committed at the next boundary, and the second load overwrites pending.
REQ-039 Bench: assert rst_n=0 mid-frame with pending=1 -> outputs inactive asynchronously, and the old data is never displayed after release.
